// File: rtl/cache_arb_pkg.sv
// Shared types and line geometry for the I$/D$ main-memory arbiter.
// Requester and state encodings live here so the latch and the top agree on them.
package cache_arb_pkg;

   localparam int S_OFFSET = 5;
   localparam int S_MASK   = 2**S_OFFSET;
   localparam int S_LINE   = 8*S_MASK;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } arb_state_t;

   typedef enum logic {
      ICACHE,
      DCACHE
   } requester_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } mem_op_t;

   // On a tie the requester that did not win last time is chosen.
   function automatic requester_t pick_winner(input logic req_i,
                                              input logic req_d,
                                              input requester_t last);
      requester_t w;
      if (req_i && req_d)
         w = (last == ICACHE) ? DCACHE : ICACHE;
      else if (req_d)
         w = DCACHE;
      else
         w = ICACHE;
      return w;
   endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Request register: captures the granted requester's address, line, byte enables
// and operation, and holds them steady for the whole memory transaction.
module arb_req_latch
   import cache_arb_pkg::*;
#(
   parameter int s_mask = S_MASK,
   parameter int s_line = S_LINE
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [31:0]       i_address,
   input  logic [s_line-1:0] i_wdata,
   input  logic [s_mask-1:0] i_byte_enable,
   input  mem_op_t           i_op,
   output logic [31:0]       o_address,
   output logic [s_line-1:0] o_wdata,
   output logic [s_mask-1:0] o_byte_enable,
   output mem_op_t           o_op
);

   logic [31:0]       r_address;
   logic [s_line-1:0] r_wdata;
   logic [s_mask-1:0] r_byte_enable;
   mem_op_t           r_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_address     <= '0;
         r_wdata       <= '0;
         r_byte_enable <= '0;
         r_op          <= OP_READ;
      end else if (i_load) begin
         r_address     <= i_address;
         r_wdata       <= i_wdata;
         r_byte_enable <= i_byte_enable;
         r_op          <= i_op;
      end
   end

   assign o_address     = r_address;
   assign o_wdata       = r_wdata;
   assign o_byte_enable = r_byte_enable;
   assign o_op          = r_op;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one 256-bit memory line port between the I$ and D$ controllers.
// Grants in IDLE, drives memory from the latched request, forwards resp to the winner only.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int s_offset = S_OFFSET,
   parameter int s_mask   = 2**s_offset,
   parameter int s_line   = 8*s_mask
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [s_line-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [s_line-1:0] d_wdata,
   input  logic [s_mask-1:0] d_byte_enable,
   output logic [s_line-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_address,
   output logic [s_line-1:0] mem_wdata,
   output logic [s_mask-1:0] mem_byte_enable,
   input  logic [s_line-1:0] mem_rdata,
   input  logic              mem_resp
);

   arb_state_t r_state;
   requester_t r_last_grant;

   logic              w_req_d;
   logic              w_any_req;
   logic              w_load;
   logic              w_busy;
   requester_t        w_winner;
   mem_op_t           w_op;
   mem_op_t           w_req_op;
   logic [31:0]       w_address;
   logic [s_line-1:0] w_wdata;
   logic [s_mask-1:0] w_byte_enable;

   assign w_req_d   = d_read | d_write;
   assign w_any_req = i_read | w_req_d;
   assign w_winner  = pick_winner(i_read, w_req_d, r_last_grant);
   assign w_load    = (r_state == IDLE) && w_any_req;

   // A D$ request with both read and write set is a write-back.
   assign w_op          = (w_winner == DCACHE && d_write) ? OP_WRITE : OP_READ;
   assign w_address     = (w_winner == DCACHE) ? d_address     : i_address;
   assign w_wdata       = (w_winner == DCACHE) ? d_wdata       : '0;
   assign w_byte_enable = (w_winner == DCACHE) ? d_byte_enable : '0;

   arb_req_latch #(
      .s_mask (s_mask),
      .s_line (s_line)
   ) u_req_latch (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_load),
      .i_address     (w_address),
      .i_wdata       (w_wdata),
      .i_byte_enable (w_byte_enable),
      .i_op          (w_op),
      .o_address     (mem_address),
      .o_wdata       (mem_wdata),
      .o_byte_enable (mem_byte_enable),
      .o_op          (w_req_op)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= ICACHE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_last_grant <= w_winner;
                  r_state      <= (w_winner == DCACHE) ? SERVE_D : SERVE_I;
               end
            end
            SERVE_I, SERVE_D: begin
               if (mem_resp)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // The command is a pure decode of registered state and the latched op.
   assign w_busy    = (r_state != IDLE);
   assign mem_read  = w_busy && (w_req_op == OP_READ);
   assign mem_write = w_busy && (w_req_op == OP_WRITE);

   // Resp is suppressed while reset is asserted so an abandoned transfer never completes.
   assign i_resp  = !rst && mem_resp && (r_state == SERVE_I);
   assign d_resp  = !rst && mem_resp && (r_state == SERVE_D);
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level arbitration model.
module tb_cache_mem_arbiter;

   localparam int LW = 256;
   localparam int MW = 32;
   typedef logic [LW-1:0] line_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [31:0]   i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [31:0]   d_address;
   logic [LW-1:0] d_wdata;
   logic [MW-1:0] d_byte_enable;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_address;
   logic [LW-1:0] mem_wdata;
   logic [MW-1:0] mem_byte_enable;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   int n_cmp = 0;
   int n_err = 0;

   cache_mem_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .i_read          (i_read),
      .i_address       (i_address),
      .i_rdata         (i_rdata),
      .i_resp          (i_resp),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_byte_enable   (d_byte_enable),
      .d_rdata         (d_rdata),
      .d_resp          (d_resp),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
   );

   always #5 clk = ~clk;

   function automatic line_t rand_line();
      line_t v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      sample();
      n_cmp++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000", {mem_read, mem_write, i_resp, d_resp});
      end
      n_cmp++;
      if (mem_address !== 32'h0) begin
         n_err++; $display("FAIL reset_addr: got %h want 0", mem_address);
      end
      n_cmp++;
      if (mem_wdata !== '0 || mem_byte_enable !== '0) begin
         n_err++; $display("FAIL reset_data: got %h/%h want 0", mem_wdata, mem_byte_enable);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_icache_alone();
      line_t pat;
      pat = {32{8'hA5}};
      step();
      i_read = 1'b1; i_address = 32'h0000_1040;
      sample();
      n_cmp++;
      if (mem_read !== 1'b0) begin
         n_err++; $display("FAIL ic_early_cmd: got %b want 0", mem_read);
      end
      step(); sample();
      n_cmp++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
         n_err++; $display("FAIL ic_cmd: got rd=%b wr=%b want rd=1 wr=0", mem_read, mem_write);
      end
      n_cmp++;
      if (mem_address !== 32'h0000_1040 || mem_wdata !== '0 || mem_byte_enable !== '0) begin
         n_err++; $display("FAIL ic_latch: got %h be=%h want 00001040 be=0", mem_address, mem_byte_enable);
      end
      repeat (2) begin
         step(); sample();
         n_cmp++;
         if (i_resp !== 1'b0 || mem_read !== 1'b1) begin
            n_err++; $display("FAIL ic_wait: got resp=%b rd=%b want resp=0 rd=1", i_resp, mem_read);
         end
      end
      step();
      mem_resp = 1'b1; mem_rdata = pat;
      sample();
      n_cmp++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         n_err++; $display("FAIL ic_resp: got i=%b d=%b want i=1 d=0", i_resp, d_resp);
      end
      n_cmp++;
      if (i_rdata !== pat) begin
         n_err++; $display("FAIL ic_rdata: got %h want %h", i_rdata, pat);
      end
      step();
      mem_resp = 1'b0; i_read = 1'b0;
      sample();
      n_cmp++;
      if (i_resp !== 1'b0 || mem_read !== 1'b0) begin
         n_err++; $display("FAIL ic_drop: got resp=%b rd=%b want 0 0", i_resp, mem_read);
      end
   endtask

   task automatic test_dcache_write();
      line_t pat;
      pat = {8{32'h1234_5678}};
      step();
      d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = pat; d_byte_enable = 32'hFFFF_FFFF;
      step(); sample();
      n_cmp++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
         n_err++; $display("FAIL dw_cmd: got rd=%b wr=%b want rd=0 wr=1", mem_read, mem_write);
      end
      n_cmp++;
      if (mem_address !== 32'h8000_0020 || mem_wdata !== pat || mem_byte_enable !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL dw_latch: got %h %h %h", mem_address, mem_wdata, mem_byte_enable);
      end
      step();
      d_wdata = ~pat; d_address = 32'hDEAD_BEE0; d_byte_enable = 32'h0000_00FF;
      sample();
      n_cmp++;
      if (mem_address !== 32'h8000_0020 || mem_wdata !== pat || mem_byte_enable !== 32'hFFFF_FFFF || mem_write !== 1'b1) begin
         n_err++; $display("FAIL dw_hold: got %h %h %h wr=%b want unchanged", mem_address, mem_wdata, mem_byte_enable, mem_write);
      end
      step();
      mem_resp = 1'b1;
      sample();
      n_cmp++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         n_err++; $display("FAIL dw_resp: got d=%b i=%b want d=1 i=0", d_resp, i_resp);
      end
      step();
      mem_resp = 1'b0; d_write = 1'b0;
      sample();
      n_cmp++;
      if (mem_write !== 1'b0 || d_resp !== 1'b0) begin
         n_err++; $display("FAIL dw_drop: got wr=%b resp=%b want 0 0", mem_write, d_resp);
      end
   endtask

   task automatic test_tie();
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_2000; exp_addr[2] = 32'h0000_3000;
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      i_read = 1'b1; d_read = 1'b1; i_address = 32'h0000_2000; d_address = 32'h0000_3000;
      for (int t = 0; t < 3; t++) begin
         step(); sample();
         n_cmp++;
         if (mem_read !== 1'b1 || mem_address !== exp_addr[t]) begin
            n_err++; $display("FAIL tie_grant%0d: got rd=%b addr=%h want rd=1 addr=%h", t, mem_read, mem_address, exp_addr[t]);
         end
         step();
         mem_resp = 1'b1;
         sample();
         n_cmp++;
         if (d_resp !== (t != 1) || i_resp !== (t == 1)) begin
            n_err++; $display("FAIL tie_resp%0d: got i=%b d=%b", t, i_resp, d_resp);
         end
         step();
         mem_resp = 1'b0;
         if (t == 2) begin i_read = 1'b0; d_read = 1'b0; end
         sample();
         n_cmp++;
         if (mem_read !== 1'b0) begin
            n_err++; $display("FAIL tie_gap%0d: got rd=%b want 0", t, mem_read);
         end
      end
   endtask

   task automatic test_spurious();
      step();
      mem_resp = 1'b1; mem_rdata = rand_line();
      sample();
      n_cmp++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         n_err++; $display("FAIL spur_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
      end
      step();
      mem_resp = 1'b0; i_read = 1'b1; i_address = 32'h0000_4440;
      sample();
      n_cmp++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_err++; $display("FAIL spur_cmd: got rd=%b wr=%b want 0 0", mem_read, mem_write);
      end
      step(); sample();
      n_cmp++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0000_4440) begin
         n_err++; $display("FAIL spur_idle: got rd=%b addr=%h want 1 00004440", mem_read, mem_address);
      end
      step();
      mem_resp = 1'b1;
      sample();
      n_cmp++;
      if (i_resp !== 1'b1) begin
         n_err++; $display("FAIL spur_after: got i_resp=%b want 1", i_resp);
      end
      step();
      mem_resp = 1'b0; i_read = 1'b0;
   endtask

   task automatic test_reset_mid();
      step();
      d_read = 1'b1; d_address = 32'h0000_5560;
      step(); sample();
      n_cmp++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0000_5560) begin
         n_err++; $display("FAIL rmid_cmd: got rd=%b addr=%h want 1 00005560", mem_read, mem_address);
      end
      step(); rst = 1'b1;
      step(); rst = 1'b0; d_read = 1'b0;
      sample();
      n_cmp++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_address !== 32'h0 || mem_wdata !== '0 || mem_byte_enable !== '0) begin
         n_err++; $display("FAIL rmid_clear: got ctl=%b addr=%h want all zero", {mem_read, mem_write, i_resp, d_resp}, mem_address);
      end
      step();
      mem_resp = 1'b1;
      sample();
      n_cmp++;
      if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
         n_err++; $display("FAIL rmid_resp: got d=%b i=%b want 0 0", d_resp, i_resp);
      end
      step();
      mem_resp = 1'b0;
   endtask

   task automatic test_rw_conflict();
      line_t wd;
      wd = rand_line();
      step();
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_7780; d_wdata = wd; d_byte_enable = 32'h0F0F_F0F0;
      step(); sample();
      n_cmp++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== wd) begin
         n_err++; $display("FAIL rw_cmd: got rd=%b wr=%b want rd=0 wr=1", mem_read, mem_write);
      end
      step();
      mem_resp = 1'b1;
      sample();
      n_cmp++;
      if (d_resp !== 1'b1) begin
         n_err++; $display("FAIL rw_resp: got %b want 1", d_resp);
      end
      step();
      mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic test_random();
      bit          pend_i, pend_d, last_d, win_d, got;
      int          dk, waited, dly;
      logic [31:0] ia, da, ea;
      line_t       dwd, rd, ewd;
      logic [MW-1:0] dbe, ebe;
      bit          ewr;
      pend_i = 0; pend_d = 0; last_d = 0; dk = 0;
      ia = '0; da = '0; dwd = '0; dbe = '0;
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (!pend_i && $urandom_range(0, 1) == 1) begin pend_i = 1; ia = $urandom; end
         if (!pend_d && $urandom_range(0, 1) == 1) begin
            pend_d = 1; da = $urandom; dwd = rand_line(); dbe = $urandom; dk = $urandom_range(0, 2);
         end
         if (!pend_i && !pend_d) begin pend_i = 1; ia = $urandom; end
         i_read = pend_i; i_address = ia;
         d_read = pend_d && (dk != 1); d_write = pend_d && (dk != 0);
         d_address = da; d_wdata = dwd; d_byte_enable = dbe;
         // reference arbitration: alternate on a tie, otherwise the lone requester
         win_d  = (pend_i && pend_d) ? !last_d : pend_d;
         last_d = win_d;
         ea  = win_d ? da : ia;
         ewr = win_d && (dk != 0);
         ewd = win_d ? dwd : '0;
         ebe = win_d ? dbe : '0;
         sample();
         n_cmp++;
         if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
            n_err++; $display("FAIL rnd_idle%0d: got %b want 0000", t, {mem_read, mem_write, i_resp, d_resp});
         end
         waited = 0; got = 0;
         while (waited < 8 && !got) begin
            step(); sample();
            waited++;
            got = mem_read | mem_write;
         end
         n_cmp++;
         if (!got || waited != 1) begin
            n_err++; $display("FAIL rnd_latency%0d: got %0d cycles (cmd=%b) want 1", t, waited, got);
         end
         n_cmp++;
         if (mem_write !== ewr || mem_read !== !ewr || mem_address !== ea || mem_wdata !== ewd || mem_byte_enable !== ebe) begin
            n_err++; $display("FAIL rnd_cmd%0d: got wr=%b addr=%h be=%h want wr=%b addr=%h be=%h", t, mem_write, mem_address, mem_byte_enable, ewr, ea, ebe);
         end
         dly = $urandom_range(0, 3);
         repeat (dly) begin
            step();
            if (win_d) begin d_address = $urandom; d_wdata = rand_line(); end
            else i_address = $urandom;
            sample();
            n_cmp++;
            if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_address !== ea || mem_wdata !== ewd) begin
               n_err++; $display("FAIL rnd_hold%0d: got addr=%h resp=%b%b want addr=%h", t, mem_address, i_resp, d_resp, ea);
            end
         end
         step();
         rd = rand_line(); mem_resp = 1'b1; mem_rdata = rd;
         sample();
         n_cmp++;
         if (d_resp !== win_d || i_resp !== !win_d || (win_d ? d_rdata : i_rdata) !== rd) begin
            n_err++; $display("FAIL rnd_resp%0d: got i=%b d=%b want d=%b", t, i_resp, d_resp, win_d);
         end
         step();
         mem_resp = 1'b0;
         if (win_d) pend_d = 0; else pend_i = 0;
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
      d_address = '0; d_wdata = '0; d_byte_enable = '0; mem_rdata = '0; mem_resp = 1'b0;
      test_reset();
      test_icache_alone();
      test_dcache_write();
      test_tie();
      test_spurious();
      test_reset_mid();
      test_rw_conflict();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single 256-bit main-memory line port between the instruction cache and the data cache. Selects one requester, latches that requester's address, write line and byte enables into a request register, and drives the memory port from that register. Returns the memory response to the selected cache only. Sits between the two cache controllers and the cacheline adaptor / physical memory.

Parameters:
s_offset, 5, line offset bits; line is 2**s_offset bytes
s_mask, 2**s_offset, byte-enable width (32)
s_line, 8*s_mask, line data width (256)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_read  in  1  icache line read request; held until i_resp
i_address  in  32  icache line address
i_rdata  out  s_line  line returned to icache
i_resp  out  1  icache completion, one-cycle pulse
d_read  in  1  dcache line read request; held until d_resp
d_write  in  1  dcache line write-back request; held until d_resp
d_address  in  32  dcache line address
d_wdata  in  s_line  dcache write line
d_byte_enable  in  s_mask  dcache write byte enables
d_rdata  out  s_line  line returned to dcache
d_resp  out  1  dcache completion, one-cycle pulse
mem_read  out  1  memory line read
mem_write  out  1  memory line write
mem_address  out  32  latched address
mem_wdata  out  s_line  latched write line
mem_byte_enable  out  s_mask  latched byte enables
mem_rdata  in  s_line  memory read line
mem_resp  in  1  memory completion, one-cycle pulse

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- States: IDLE, SERVE_I, SERVE_D.
- Reset (synchronous, takes priority over everything):
  - state=IDLE, last_grant=ICACHE.
  - Request register (address, wdata, byte enable, op) = 0.
  - All outputs 0: mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, i_resp, d_resp.
- IDLE: on a clock edge where any request is high:
  - Latch the winner's address, wdata and byte enables. For icache, latch wdata=0 and byte_enable=0.
  - Latch op: write if d_write, else read.
  - Move to the SERVE state. No memory command is issued in IDLE.
- Arbitration in IDLE:
  - Only one cache requesting: that cache wins.
  - Both requesting: the cache not equal to last_grant wins.
  - last_grant updates on each grant.
  - After reset, a tie goes to the dcache.
- SERVE_x:
  - mem_read/mem_write = latched op; mem_* data comes from the request register.
  - Latency: request first seen in cycle N → memory command visible in cycle N+1.
- mem_resp in SERVE_x:
  - x_resp=1 combinationally in the same cycle.
  - Next state IDLE; the memory command drops in the next cycle.
- i_rdata and d_rdata are always driven from mem_rdata. Only resp is gated.
- Back-to-back requests: resp in cycle M, IDLE in M+1, next command in M+2. Minimum one idle cycle between transactions.
- Boundary cases:
  - d_read and d_write both high: treated as a write.
  - Requester inputs change during SERVE: ignored. The latched request completes unchanged.
  - mem_resp while in IDLE: ignored. No resp pulse to either cache.
  - Reset mid-transaction: next cycle IDLE with all outputs 0. The in-flight memory transaction is abandoned and no resp is forwarded.
  - Request lines dropped without resp: protocol violation. The arbiter still completes and pulses resp.

Decomposition:
- Package cache_arb_pkg:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - requester_t enum {ICACHE, DCACHE}
  - line/mask width constants derived from s_offset
- One sub-module: arb_req_latch.
  - Request register: load enable, address, wdata, byte enable and op.
  - Synchronous reset to 0.
- The FSM and arbitration stay in cache_mem_arbiter.

Test Plan:
- Icache alone:
  - Stimulus: i_read=1, i_address=0x0000_1040; mem_resp 3 cycles after mem_read rises, mem_rdata=0xA5..A5.
  - Expect: mem_read one cycle after the request, mem_address=0x0000_1040, mem_write=0; i_resp pulses one cycle with i_rdata=0xA5..A5; d_resp=0.
- Dcache write-back:
  - Stimulus: d_write=1, d_address=0x8000_0020, d_wdata=0x1234...(pattern), d_byte_enable=0xFFFF_FFFF.
  - Expect: mem_write=1 with latched values; values stay unchanged when d_wdata is altered mid-transaction; d_resp on mem_resp.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read high in the same cycle.
  - Expect: dcache served first, then icache starts 2 cycles after d_resp; a repeat tie alternates the winner.
- Spurious response:
  - Stimulus: mem_resp pulsed while IDLE.
  - Expect: no i_resp/d_resp; state stays IDLE.
- Reset mid-transaction:
  - Stimulus: rst asserted during SERVE_D (d_read active).
  - Expect: next cycle all outputs 0, state IDLE; a later mem_resp produces no d_resp.
- Read/write conflict:
  - Stimulus: d_read=1 and d_write=1.
  - Expect: mem_write=1, mem_read=0.
